mdu_seq: RTL and testbench

- Multi-cycle sequencer for RV32M multiply/divide, placed beside the single-cycle EX ALU.
- When decode flags an OP_R instruction with funct7 = 7'b0000001, EX hands the operands to this block.
- The block holds the pipeline stalled while an iterative shift-add / shift-subtract datapath runs. It then returns a write-back triple (rd_we, rd_addr, rd_data) in the same form EX produces.

---
 rtl/mdu_seq_pkg.sv | 29 ++
 rtl/mdu_iter.sv | 71 +++++++
 rtl/mdu_seq.sv | 166 ++++++++++++++++
 tb/tb_mdu_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
package mdu_seq_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // All divide/remainder encodings have funct3[2] set.
  function automatic logic isDivOp(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative shift-add multiplier / restoring divider datapath.
// Multiply: {hi,lo} starts as {0,A}; each step adds B to hi when lo[0] is set,
// then shifts the 65-bit sum right, leaving the 64-bit product in {hi,lo}.
// Divide: lo starts as the dividend and shifts left into hi (partial remainder);
// each step trial-subtracts B and shifts the quotient bit into lo.
module mdu_iter
  import mdu_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            isDiv_i,
  input  logic [XLEN-1:0] opA_i,
  input  logic [XLEN-1:0] opB_i,
  output logic [XLEN-1:0] stepHi_o,
  output logic [XLEN-1:0] stepLo_o
);

  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic            isDiv_q;
  logic [XLEN:0]   sum, shifted, diff;

  // One iteration of the selected algorithm, exposed so the sequencer can
  // capture the final result on the same edge as the last step.
  always_comb begin
    sum      = {1'b0, hi_q} + {1'b0, b_q};
    shifted  = {hi_q, lo_q[XLEN-1]};
    diff     = shifted - {1'b0, b_q};
    stepHi_o = hi_q;
    stepLo_o = lo_q;
    if (isDiv_q) begin
      if (!diff[XLEN]) begin
        stepHi_o = diff[XLEN-1:0];
        stepLo_o = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        stepHi_o = shifted[XLEN-1:0];
        stepLo_o = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      if (lo_q[0]) begin
        stepHi_o = sum[XLEN:1];
        stepLo_o = {sum[0], lo_q[XLEN-1:1]};
      end else begin
        stepHi_o = {1'b0, hi_q[XLEN-1:1]};
        stepLo_o = {hi_q[0], lo_q[XLEN-1:1]};
      end
    end
  end

  // Operand load on request accept, one step per enabled cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      isDiv_q <= 1'b0;
    end else if (load_i) begin
      hi_q    <= '0;
      lo_q    <= opA_i;
      b_q     <= opB_i;
      isDiv_q <= isDiv_i;
    end else if (step_i) begin
      hi_q    <= stepHi_o;
      lo_q    <= stepLo_o;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// RV32M multi-cycle sequencer: FSM, iteration counter, special-case
// detection, sign fixup and pipeline stall/write-back handshake.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic            rd_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              negRes_q, negRes_d;
  logic [4:0]        rdAddrReq_q, rdAddrReq_d;
  logic [4:0]        rdAddr_q, rdAddr_d;
  logic [XLEN-1:0]   rdData_q, rdData_d;

  logic              aSigned, bSigned, aNeg, bNeg, reqNeg;
  logic [XLEN-1:0]   aMag, bMag;
  logic              divZero, divOvf, special;
  logic [XLEN-1:0]   specialRes;
  logic              accept, iterLoad, iterStep;
  logic [XLEN-1:0]   stepHi, stepLo;
  logic [2*XLEN-1:0] prod, prodFix;
  logic [XLEN-1:0]   finalRes;

  mdu_iter #(.XLEN(XLEN)) uIter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (iterLoad),
    .step_i   (iterStep),
    .isDiv_i  (isDivOp(funct3_i)),
    .opA_i    (aMag),
    .opB_i    (bMag),
    .stepHi_o (stepHi),
    .stepLo_o (stepLo)
  );

  // Decode the incoming request: operand magnitudes, result sign, special divides.
  always_comb begin
    aSigned = (funct3_i != F3_MULHU) && (funct3_i != F3_DIVU) && (funct3_i != F3_REMU);
    bSigned = (funct3_i == F3_MUL) || (funct3_i == F3_MULH) ||
              (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    aNeg    = aSigned && rs1_data_i[XLEN-1];
    bNeg    = bSigned && rs2_data_i[XLEN-1];
    aMag    = aNeg ? -rs1_data_i : rs1_data_i;
    bMag    = bNeg ? -rs2_data_i : rs2_data_i;
    reqNeg  = ((funct3_i == F3_REM) || (funct3_i == F3_REMU)) ? aNeg : (aNeg ^ bNeg);
    divZero = isDivOp(funct3_i) && (rs2_data_i == '0);
    divOvf  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
              (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1);
    special = divZero || divOvf;
    specialRes = '0;
    if (divZero) begin
      specialRes = funct3_i[1] ? rs1_data_i : '1;
    end else if (divOvf) begin
      specialRes = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // Sign-corrected result taken from the final iteration step.
  always_comb begin
    prod     = {stepHi, stepLo};
    prodFix  = negRes_q ? -prod : prod;
    finalRes = '0;
    case (funct3_q)
      F3_MUL:                       finalRes = prodFix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: finalRes = prodFix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              finalRes = negRes_q ? -stepLo : stepLo;
      default:                      finalRes = negRes_q ? -stepHi : stepHi;
    endcase
  end

  // Next-state, datapath control and handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    negRes_d    = negRes_q;
    rdAddrReq_d = rdAddrReq_q;
    rdAddr_d    = rdAddr_q;
    rdData_d    = rdData_q;
    iterLoad    = 1'b0;
    iterStep    = 1'b0;
    accept      = start_i && !flush_i &&
                  ((state_q == ST_IDLE) || (state_q == ST_DONE));

    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_CALC: begin
          iterStep = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = ST_DONE;
            rdData_d = finalRes;
            rdAddr_d = rdAddrReq_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          if (accept) begin
            iterLoad    = 1'b1;
            funct3_d    = funct3_i;
            negRes_d    = reqNeg;
            rdAddrReq_d = rd_addr_i;
            cnt_d       = CNT_W'(XLEN);
            if (special) begin
              state_d  = ST_DONE;
              rdData_d = specialRes;
              rdAddr_d = rd_addr_i;
            end else begin
              state_d  = ST_CALC;
            end
          end
        end
      endcase
    end

    valid_o = (state_q == ST_DONE);
    rd_we   = valid_o;
    busy_o  = (state_q != ST_IDLE);
    stall_o = !flush_i && (((state_q == ST_IDLE) && start_i) || (state_q == ST_CALC));
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      funct3_q    <= '0;
      negRes_q    <= 1'b0;
      rdAddrReq_q <= '0;
      rdAddr_q    <= '0;
      rdData_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      negRes_q    <= negRes_d;
      rdAddrReq_q <= rdAddrReq_d;
      rdAddr_q    <= rdAddr_d;
      rdData_q    <= rdData_d;
    end
  end

  assign rd_addr = rdAddr_q;
  assign rd_data = rdData_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for the RV32M multiply/divide sequencer.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        stall_o, busy_o, valid_o, rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  mdu_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .rd_we      (rd_we),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic driveInputs(input bit start, input bit flush, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    start_i    = start;
    flush_i    = flush;
    funct3_i   = f3;
    rs1_data_i = a;
    rs2_data_i = b;
    rd_addr_i  = rd;
  endtask

  task automatic applyStimulus(input bit start, input bit flush, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    driveInputs(start, flush, f3, a, b, rd);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic runOp(input string tag, input bit b2b, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] expData, input int expCyc);
    int cyc;
    int stallCnt;
    bit seen;
    if (b2b) begin
      driveInputs(1'b1, 1'b0, f3, a, b, rd);
      #1;
    end else begin
      applyStimulus(1'b1, 1'b0, f3, a, b, rd);
    end
    stallCnt = stall_o ? 1 : 0;
    cyc      = 1;
    seen     = 1'b0;
    while (!seen && cyc < 60) begin
      idleCycle();
      cyc++;
      if (valid_o) seen = 1'b1;
      else if (stall_o) stallCnt++;
    end
    checkOutput({tag, " valid cycle"}, 32'(cyc), 32'(expCyc));
    checkOutput({tag, " stall cycles"}, 32'(stallCnt), b2b ? 32'(expCyc - 2) : 32'(expCyc - 1));
    checkOutput({tag, " rd_data"}, rd_data, expData);
    checkOutput({tag, " rd_addr"}, 32'(rd_addr), 32'(rd));
    checkOutput({tag, " rd_we"}, 32'(rd_we), 32'd1);
  endtask

  task automatic expectNoValid(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      idleCycle();
      if (valid_o) seen = 1'b1;
    end
    checkOutput(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    $display("[TB] starting mdu_seq directed test");

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset rd_data", rd_data, 32'd0);
    checkOutput("reset rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("reset valid_o", 32'(valid_o), 32'd0);
    checkOutput("reset rd_we", 32'(rd_we), 32'd0);
    checkOutput("reset busy_o", 32'(busy_o), 32'd0);
    checkOutput("reset stall_o", 32'(stall_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Multiplies
    runOp("MUL 7*-3", 1'b0, F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 34);
    idleCycle();
    checkOutput("MUL pulse ends", 32'(valid_o), 32'd0);
    checkOutput("MUL data holds", rd_data, 32'hFFFF_FFEB);
    runOp("MULH", 1'b0, F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 34);
    runOp("MULHU", 1'b0, F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 34);
    runOp("MULHSU", 1'b0, F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 34);

    // Divides
    runOp("DIV -7/2", 1'b0, F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 34);
    runOp("REM -7/2", 1'b0, F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 34);
    runOp("DIVU 100/7", 1'b0, F3_DIVU, 32'd100, 32'd7, 5'd13, 32'd14, 34);
    runOp("REMU 100/7", 1'b0, F3_REMU, 32'd100, 32'd7, 5'd10, 32'd2, 34);

    // Flush in cycle 10 of a DIV
    applyStimulus(1'b1, 1'b0, F3_DIV, 32'd100, 32'd7, 5'd3);
    for (int i = 2; i <= 9; i++) idleCycle();
    applyStimulus(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 5'd0);
    checkOutput("flush stall low", 32'(stall_o), 32'd0);
    idleCycle();
    checkOutput("flush busy low", 32'(busy_o), 32'd0);
    checkOutput("flush valid low", 32'(valid_o), 32'd0);
    checkOutput("flush rd_data kept", rd_data, 32'd2);
    checkOutput("flush rd_addr kept", 32'(rd_addr), 32'd10);
    expectNoValid("flush no valid", 40);

    // Flush and start together in IDLE
    applyStimulus(1'b1, 1'b1, F3_MUL, 32'd3, 32'd4, 5'd4);
    checkOutput("flush+start stall", 32'(stall_o), 32'd0);
    idleCycle();
    checkOutput("flush+start busy", 32'(busy_o), 32'd0);
    expectNoValid("flush+start no valid", 40);

    // Special divides
    runOp("REM ovf", 1'b0, F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 2);
    runOp("DIV ovf", 1'b0, F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 2);
    runOp("REMU 5/0", 1'b0, F3_REMU, 32'd5, 32'd0, 5'd19, 32'd5, 2);
    runOp("DIVU 5/0", 1'b0, F3_DIVU, 32'd5, 32'd0, 5'd20, 32'hFFFF_FFFF, 2);

    // Reset in cycle 15 of a MUL
    applyStimulus(1'b1, 1'b0, F3_MUL, 32'd9, 32'd9, 5'd12);
    for (int i = 2; i <= 14; i++) idleCycle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset rd_data", rd_data, 32'd0);
    checkOutput("midreset rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("midreset valid_o", 32'(valid_o), 32'd0);
    checkOutput("midreset rd_we", 32'(rd_we), 32'd0);
    checkOutput("midreset busy_o", 32'(busy_o), 32'd0);
    checkOutput("midreset stall_o", 32'(stall_o), 32'd0);
    expectNoValid("midreset no valid", 40);

    // Back-to-back starts issued in the DONE cycle
    runOp("b2b MULHU", 1'b0, F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 32'hFFFF_FFFE, 34);
    runOp("b2b DIVU", 1'b1, F3_DIVU, 32'd100, 32'd7, 5'd22, 32'd14, 34);
    runOp("b2b REMU 5/0", 1'b1, F3_REMU, 32'd5, 32'd0, 5'd23, 32'd5, 2);
    idleCycle();
    checkOutput("b2b idle after", 32'(busy_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
